// File: rtl/pri_enc_8to3.sv
// pri_enc_8to3: registered 8-to-3 priority encoder, d7 highest priority.
//
// Outputs {q2,q1,q0} carry the index of the highest asserted request line
// and vld flags that at least one line was high; both are captured on the
// rising edge of clk, so there is exactly one cycle of latency and no
// combinational path from d* to the outputs.
//
// Build option (macro PRI_ENC_8TO3_HOLD_EN):
//   undefined (default) - an all-zero sample registers code 000, vld 0.
//   defined             - an all-zero sample keeps the previous code, vld 0.
// Ports, latency and reset behaviour are identical in both builds.

module pri_enc_8to3 (
    input  logic clk,
    input  logic rst_n,
    input  logic d0,
    input  logic d1,
    input  logic d2,
    input  logic d3,
    input  logic d4,
    input  logic d5,
    input  logic d6,
    input  logic d7,
    output logic q0,
    output logic q1,
    output logic q2,
    output logic vld
);

    logic [7:0] req;
    logic [2:0] idx;
    logic       any_req;
    logic [2:0] code_d, code_q;
    logic       vld_d, vld_q;

    assign req = {d7, d6, d5, d4, d3, d2, d1, d0};

    // Priority search from the top down. Once a line tests true the lower
    // lines are never examined, so X/Z below the winner cannot leak out.
    always_comb begin
        idx     = 3'd0;
        any_req = 1'b0;
        if (req[7]) begin
            idx     = 3'd7;
            any_req = 1'b1;
        end else if (req[6]) begin
            idx     = 3'd6;
            any_req = 1'b1;
        end else if (req[5]) begin
            idx     = 3'd5;
            any_req = 1'b1;
        end else if (req[4]) begin
            idx     = 3'd4;
            any_req = 1'b1;
        end else if (req[3]) begin
            idx     = 3'd3;
            any_req = 1'b1;
        end else if (req[2]) begin
            idx     = 3'd2;
            any_req = 1'b1;
        end else if (req[1]) begin
            idx     = 3'd1;
            any_req = 1'b1;
        end else if (req[0]) begin
            idx     = 3'd0;
            any_req = 1'b1;
        end
    end

    // Next-state selection: idle samples either clear or hold the code.
    always_comb begin
        vld_d = any_req;
`ifdef PRI_ENC_8TO3_HOLD_EN
        code_d = any_req ? idx : code_q;
`else
        code_d = any_req ? idx : 3'd0;
`endif
    end

    // Output registers; reset clears them immediately, without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q <= 3'd0;
            vld_q  <= 1'b0;
        end else begin
            code_q <= code_d;
            vld_q  <= vld_d;
        end
    end

    assign q0  = code_q[0];
    assign q1  = code_q[1];
    assign q2  = code_q[2];
    assign vld = vld_q;

endmodule

// File: tb/tb_pri_enc_8to3.sv
// tb_pri_enc_8to3: scoreboard bench for pri_enc_8to3.
// The driver applies inputs on the falling edge and queues the expected
// registered result; the monitor pops one entry per rising edge.

module tb_pri_enc_8to3;

    logic clk;
    logic rst_n;
    logic d0, d1, d2, d3, d4, d5, d6, d7;
    logic q0, q1, q2, vld;

    int total;
    int bad;

    typedef struct {
        logic [2:0] code;
        logic       v;
        int         tag;
    } exp_t;

    exp_t       sb_q[$];
    logic [2:0] model_code;
    int         tag_cnt;

    pri_enc_8to3 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .d0    (d0),
        .d1    (d1),
        .d2    (d2),
        .d3    (d3),
        .d4    (d4),
        .d5    (d5),
        .d6    (d6),
        .d7    (d7),
        .q0    (q0),
        .q1    (q1),
        .q2    (q2),
        .vld   (vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got q/vld=%b expected %b at %0t", name, got, want, $time);
        end
    endtask

    task automatic set_d(input logic [7:0] v);
        {d7, d6, d5, d4, d3, d2, d1, d0} = v;
    endtask

    // Reference: the winner is the largest n with 2**n <= value of the
    // known request pattern; an all-zero pattern has no winner.
    task automatic push_expect(input logic [7:0] care);
        exp_t e;
        int   n;
        n = -1;
        for (int k = 7; k >= 0; k--) begin
            if (n < 0 && int'(care) >= (1 << k)) n = k;
        end
        if (n >= 0) begin
            model_code = 3'(n);
            e.v        = 1'b1;
        end else begin
`ifndef PRI_ENC_8TO3_HOLD_EN
            model_code = 3'd0;
`endif
            e.v = 1'b0;
        end
        e.code = model_code;
        e.tag  = tag_cnt++;
        sb_q.push_back(e);
    endtask

    // Drive a vector (possibly holding X) before the next rising edge.
    task automatic drive(input logic [7:0] v, input logic [7:0] care);
        @(negedge clk);
        set_d(v);
        push_expect(care);
    endtask

    // Monitor: compare the registered outputs after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check($sformatf("sb#%0d", e.tag), {q2, q1, q0, vld}, {e.code, e.v});
            end
        end
    end

    task automatic drain();
        int budget;
        budget = 0;
        while (sb_q.size() > 0 && budget < 10) begin
            @(posedge clk);
            budget++;
        end
        #2;
        total++;
        if (sb_q.size() > 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] xv;
        total      = 0;
        bad        = 0;
        tag_cnt    = 0;
        model_code = 3'd0;
        rst_n      = 1'b0;
        set_d(8'h00);

        // Reset state before any clock edge
        #2;
        check("reset_init", {q2, q1, q0, vld}, 4'b0000);

        @(negedge clk);
        rst_n = 1'b1;

        // Walking one with X below the active line, zeros above
        for (int i = 0; i < 8; i++) begin
            xv = 8'h00;
            for (int b = 0; b < i; b++) xv[b] = 1'bx;
            xv[i] = 1'b1;
            drive(xv, 8'(1 << i));
        end

        // Multiple active lines
        drive(8'b0101_1010, 8'b0101_1010);
        drive(8'b0000_0011, 8'b0000_0011);

        // Idle after d3
        drive(8'b0000_1000, 8'b0000_1000);
        drive(8'h00, 8'h00);
        drive(8'h00, 8'h00);

        // Latency: d2 -> d6 changed between edges
        drive(8'b0000_0100, 8'b0000_0100);
        drain();
        set_d(8'b0100_0000);
        #1;
        check("latency_hold", {q2, q1, q0, vld}, 4'b0101);
        push_expect(8'b0100_0000);
        drain();

        // Async reset with q=111, asserted between edges
        drive(8'h80, 8'h80);
        drain();
        rst_n = 1'b0;
        #1;
        check("async_rst", {q2, q1, q0, vld}, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            d7 = ~d7;
            @(posedge clk);
            #1;
            check($sformatf("rst_hold%0d", i), {q2, q1, q0, vld}, 4'b0000);
        end
        model_code = 3'd0;
        @(negedge clk);
        rst_n = 1'b1;
        set_d(8'b0010_0000);
        push_expect(8'b0010_0000);
        drain();

        // Random regression, some idle cycles mixed in
        for (int i = 0; i < 1000; i++) begin
            v = 8'($urandom);
            if ($urandom_range(0, 7) == 0) v = 8'h00;
            drive(v, v);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
